// File: rtl/turtle_exec_pkg.sv
// Shared execute-stage types: ALU opcode constants, issue FSM states and the
// held instruction record presented to the execute unit.
package turtle_exec_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} issue_state_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
  } instr_t;

endpackage

// File: rtl/execute_issue.sv
// Issues one decoded instruction at a time to the execute unit and returns its result on wb_*.
// Accept-to-wb_valid is 2 cycles plus one per WAIT cycle; in_ready drops while busy or while wb is stalled.
module execute_issue
  import turtle_exec_pkg::*;
#(
  parameter int TIMEOUT = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,

  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [4:0]  in_rd,

  output logic [6:0]  unit_opcode,
  output logic [2:0]  unit_funct3,
  output logic [6:0]  unit_funct7,
  output logic [31:0] unit_imm,
  output logic [31:0] unit_rs1_val,
  output logic [31:0] unit_rs2_val,
  output logic        unit_read_valid,
  output logic        unit_flush,
  input  logic        unit_processing,
  input  logic        unit_valid,
  input  logic [31:0] unit_rd_val,

  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_val,

  output logic        err_illegal,
  output logic        err_timeout
);

  issue_state_t state;
  instr_t       hold;
  instr_t       in_instr;
  logic [2:0]   wait_cnt;
  logic [31:0]  result;
  logic         accept;
  logic         timeout_hit;

  assign in_instr = '{
    opcode:  in_opcode,
    funct3:  in_funct3,
    funct7:  in_funct7,
    imm:     in_imm,
    rs1_val: in_rs1_val,
    rs2_val: in_rs2_val,
    rd:      in_rd
  };

  assign in_ready = !flush && (state == IDLE || (state == WB && wb_ready));
  assign accept   = in_valid && in_ready;

  // wait_cnt holds the number of WAIT cycles entered so far, including the current one.
  assign timeout_hit = (state == WAIT) && !unit_valid && (wait_cnt == 3'(TIMEOUT));

  // Error pulses are dropped whenever the instruction is being abandoned anyway.
  assign err_illegal = (state == ISSUE) && !unit_processing && !flush && !reset;
  assign err_timeout = timeout_hit && !flush && !reset;
  assign unit_flush  = flush || err_timeout;

  assign unit_read_valid = (state == ISSUE);
  assign wb_valid        = (state == WB) && !flush;

  assign unit_opcode  = hold.opcode;
  assign unit_funct3  = hold.funct3;
  assign unit_funct7  = hold.funct7;
  assign unit_imm     = hold.imm;
  assign unit_rs1_val = hold.rs1_val;
  assign unit_rs2_val = hold.rs2_val;
  assign wb_rd        = hold.rd;
  assign wb_val       = result;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold     <= '0;
      wait_cnt <= '0;
      result   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            hold     <= in_instr;
            wait_cnt <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (!unit_processing) begin
            state <= IDLE;
          end else if (unit_valid) begin
            result <= unit_rd_val;
            state  <= WB;
          end else begin
            wait_cnt <= 3'd1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (unit_valid) begin
            result <= unit_rd_val;
            state  <= WB;
          end else if (timeout_hit) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        WB: begin
          // Retiring and accepting in the same cycle keeps back-to-back issue bubble-free.
          if (wb_ready) begin
            if (accept) begin
              hold     <= in_instr;
              wait_cnt <= '0;
              state    <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_issue.sv
// Directed and random checks of execute_issue against a shift-unit reference model.
module tb_execute_issue;
  import turtle_exec_pkg::*;

  localparam int TO = 7;

  typedef struct packed {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } txn_t;

  logic        clk, reset, flush;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm, in_rs1_val, in_rs2_val;
  logic [4:0]  in_rd;
  logic [6:0]  unit_opcode;
  logic [2:0]  unit_funct3;
  logic [6:0]  unit_funct7;
  logic [31:0] unit_imm, unit_rs1_val, unit_rs2_val;
  logic        unit_read_valid, unit_flush, unit_processing, unit_valid;
  logic [31:0] unit_rd_val;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;
  logic        err_illegal, err_timeout;

  int total = 0;
  int bad   = 0;

  execute_issue #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_rd(in_rd),
    .unit_opcode(unit_opcode), .unit_funct3(unit_funct3), .unit_funct7(unit_funct7),
    .unit_imm(unit_imm), .unit_rs1_val(unit_rs1_val), .unit_rs2_val(unit_rs2_val),
    .unit_read_valid(unit_read_valid), .unit_flush(unit_flush),
    .unit_processing(unit_processing), .unit_valid(unit_valid), .unit_rd_val(unit_rd_val),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_val(wb_val),
    .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift unit semantics: SLL/SRL/SRA on OP, shift amount from imm on OP_IMM.
  function automatic logic legal(input txn_t t);
    logic op_ok, fn_ok;
    op_ok = (t.opc == OP) || (t.opc == OP_IMM);
    fn_ok = (t.f3 == 3'b001 && t.f7 == 7'h00) ||
            (t.f3 == 3'b101 && (t.f7 == 7'h00 || t.f7 == 7'h20));
    return op_ok && fn_ok;
  endfunction

  function automatic logic [31:0] ref_result(input txn_t t);
    logic [4:0]         sh;
    logic signed [31:0] s;
    sh = (t.opc == OP) ? t.rs2[4:0] : t.imm[4:0];
    s  = t.rs1;
    if (t.f3 == 3'b001) return t.rs1 << sh;
    if (t.f7 == 7'h20)  return 32'(s >>> sh);
    return t.rs1 >> sh;
  endfunction

  function automatic txn_t unit_txn();
    txn_t u;
    u = '{opc: unit_opcode, f3: unit_funct3, f7: unit_funct7, imm: unit_imm,
          rs1: unit_rs1_val, rs2: unit_rs2_val, rd: 5'd0};
    return u;
  endfunction

  task automatic send(input txn_t t);
    in_opcode  = t.opc;
    in_funct3  = t.f3;
    in_funct7  = t.f7;
    in_imm     = t.imm;
    in_rs1_val = t.rs1;
    in_rs2_val = t.rs2;
    in_rd      = t.rd;
    in_valid   = 1'b1;
  endtask

  // Acts as the execute unit from the ISSUE cycle; result arrives after `waits` WAIT cycles.
  task automatic run_exec(input txn_t t, input int waits, output bit reached);
    txn_t        u;
    logic        ok, exp_to;
    logic [31:0] v;
    u  = unit_txn();
    ok = legal(u);
    v  = ref_result(u);
    unit_processing = ok;
    unit_valid      = ok && (waits == 0);
    unit_rd_val     = (ok && waits == 0) ? v : 32'hDEAD_BEEF;
    #1;
    chk("issue_strobe", 32'(unit_read_valid), 1);
    chk("unit_ctl", 32'({unit_opcode, unit_funct3, unit_funct7}), 32'({t.opc, t.f3, t.f7}));
    chk("unit_imm", unit_imm, t.imm);
    chk("unit_rs1", unit_rs1_val, t.rs1);
    chk("unit_rs2", unit_rs2_val, t.rs2);
    chk("issue_err_illegal", 32'(err_illegal), 32'(!legal(t)));
    chk("issue_wb_valid", 32'(wb_valid), 0);
    if (!legal(t)) begin
      step();
      unit_processing = 1'b0;
      unit_valid      = 1'b0;
      #1;
      chk("illegal_next_ready", 32'(in_ready), 1);
      chk("illegal_pulse_end", 32'(err_illegal), 0);
      reached = 1'b0;
      return;
    end
    if (waits == 0) begin
      step();
      unit_processing = 1'b0;
      unit_valid      = 1'b0;
      reached = 1'b1;
      return;
    end
    for (int k = 1; k <= TO; k++) begin
      step();
      unit_valid  = (waits == k);
      unit_rd_val = (waits == k) ? v : 32'hDEAD_BEEF;
      exp_to      = (k == TO) && (waits != k);
      #1;
      chk("wait_strobe", 32'(unit_read_valid), 0);
      chk("wait_wb_valid", 32'(wb_valid), 0);
      chk("wait_rs1_stable", unit_rs1_val, t.rs1);
      chk("wait_err_timeout", 32'(err_timeout), 32'(exp_to));
      chk("wait_unit_flush", 32'(unit_flush), 32'(exp_to));
      if (waits == k) begin
        step();
        unit_processing = 1'b0;
        unit_valid      = 1'b0;
        reached = 1'b1;
        return;
      end
      if (exp_to) begin
        step();
        unit_processing = 1'b0;
        unit_valid      = 1'b0;
        #1;
        chk("timeout_next_ready", 32'(in_ready), 1);
        chk("timeout_pulse_end", 32'(err_timeout), 0);
        chk("timeout_flush_end", 32'(unit_flush), 0);
        reached = 1'b0;
        return;
      end
    end
    reached = 1'b0;
  endtask

  task automatic run_wb(input logic [4:0] rd, input logic [31:0] val, input int stall,
                        input bit chain, input txn_t nxt);
    for (int s = 0; s <= stall; s++) begin
      wb_ready = (s == stall);
      if (s == stall && chain) send(nxt);
      #1;
      chk("wb_valid", 32'(wb_valid), 1);
      chk("wb_rd", 32'(wb_rd), 32'(rd));
      chk("wb_val", wb_val, val);
      chk("wb_in_ready", 32'(in_ready), 32'(s == stall));
      step();
    end
    in_valid = 1'b0;
    wb_ready = 1'b1;
  endtask

  task automatic do_txn(input txn_t t, input int waits, input int stall, input logic [31:0] exp_val);
    bit reached;
    send(t);
    #1;
    chk("accept_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    run_exec(t, waits, reached);
    if (reached) run_wb(t.rd, exp_val, stall, 1'b0, t);
    #1;
    chk("idle_wb_valid", 32'(wb_valid), 0);
    chk("idle_ready", 32'(in_ready), 1);
    chk("idle_strobe", 32'(unit_read_valid), 0);
  endtask

  initial begin
    txn_t t, a, b;
    bit   r;
    int   waits, stall;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
    unit_processing = 1'b0; unit_valid = 1'b0; unit_rd_val = '0;
    send('0); in_valid = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_strobe", 32'(unit_read_valid), 0);
    chk("rst_errs", 32'({err_illegal, err_timeout, unit_flush}), 0);
    chk("rst_hold", unit_rs1_val, 0);
    chk("rst_result", wb_val, 0);
    chk("rst_wb_rd", 32'(wb_rd), 0);

    // SLLI x5, x1(=1), 3
    t = '{opc: OP_IMM, f3: 3'b001, f7: 7'h00, imm: 32'd3, rs1: 32'd1, rs2: $urandom, rd: 5'd5};
    do_txn(t, 0, 0, 32'h0000_0008);

    // SRA 0x80000000 by 20 with two WAIT cycles
    t = '{opc: OP, f3: 3'b101, f7: 7'h20, imm: 32'd0, rs1: 32'h8000_0000, rs2: 32'd20, rd: 5'd7};
    do_txn(t, 2, 0, 32'hFFFF_F800);

    // SLL with funct7 0x20 is rejected by the unit
    t = '{opc: OP, f3: 3'b001, f7: 7'h20, imm: 32'd0, rs1: 32'h1234_5678, rs2: 32'd4, rd: 5'd9};
    do_txn(t, 0, 0, 32'h0);

    // Result on the last permitted WAIT cycle still writes back
    t = '{opc: OP, f3: 3'b001, f7: 7'h00, imm: 32'd0, rs1: 32'h0000_00FF, rs2: 32'd8, rd: 5'd3};
    do_txn(t, TO, 1, 32'h0000_FF00);

    // Unit never answers
    t = '{opc: OP, f3: 3'b101, f7: 7'h00, imm: 32'd0, rs1: 32'hFFFF_0000, rs2: 32'd1, rd: 5'd4};
    do_txn(t, 100, 0, 32'h0);

    // Flush during WAIT of SLL by 31; a new instruction offered that cycle is refused
    t = '{opc: OP, f3: 3'b001, f7: 7'h00, imm: 32'd0, rs1: 32'h0000_0003, rs2: 32'd31, rd: 5'd6};
    send(t); step(); in_valid = 1'b0;
    unit_processing = 1'b1; unit_valid = 1'b0; unit_rd_val = 32'hDEAD_BEEF;
    #1;
    chk("fl_issue_strobe", 32'(unit_read_valid), 1);
    step();
    flush = 1'b1;
    send(t);
    #1;
    chk("fl_unit_flush", 32'(unit_flush), 1);
    chk("fl_in_ready", 32'(in_ready), 0);
    chk("fl_err_timeout", 32'(err_timeout), 0);
    chk("fl_wb_valid", 32'(wb_valid), 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    unit_valid = 1'b1; unit_rd_val = 32'h8000_0000;
    #1;
    chk("fl_idle_ready", 32'(in_ready), 1);
    chk("fl_not_issued", 32'(unit_read_valid), 0);
    chk("fl_unit_flush_off", 32'(unit_flush), 0);
    step();
    unit_processing = 1'b0; unit_valid = 1'b0;
    #1;
    chk("fl_no_wb", 32'(wb_valid), 0);

    // Flush while holding a writeback
    t = '{opc: OP_IMM, f3: 3'b101, f7: 7'h00, imm: 32'd4, rs1: 32'h0000_0F00, rs2: 32'd0, rd: 5'd2};
    send(t); step(); in_valid = 1'b0;
    run_exec(t, 0, r);
    flush = 1'b1;
    #1;
    chk("flwb_wb_valid", 32'(wb_valid), 0);
    chk("flwb_unit_flush", 32'(unit_flush), 1);
    step();
    flush = 1'b0;
    #1;
    chk("flwb_idle_ready", 32'(in_ready), 1);
    chk("flwb_gone", 32'(wb_valid), 0);

    // Writeback stalled 3 cycles, then retire and accept the next instruction together
    a = '{opc: OP, f3: 3'b101, f7: 7'h00, imm: 32'd0, rs1: 32'hF000_0000, rs2: 32'd4, rd: 5'd10};
    b = '{opc: OP_IMM, f3: 3'b001, f7: 7'h00, imm: 32'd2, rs1: 32'h0000_0003, rs2: 32'd0, rd: 5'd11};
    send(a); step(); in_valid = 1'b0;
    run_exec(a, 0, r);
    run_wb(a.rd, 32'h0F00_0000, 3, 1'b1, b);
    run_exec(b, 1, r);
    run_wb(b.rd, 32'h0000_000C, 0, 1'b0, b);
    #1;
    chk("b2b_idle", 32'(wb_valid), 0);

    // Reset in ISSUE with the unit refusing: no error pulse, abandoned cleanly
    t = '{opc: OP, f3: 3'b001, f7: 7'h00, imm: 32'd0, rs1: 32'h0000_0055, rs2: 32'd1, rd: 5'd12};
    send(t); step(); in_valid = 1'b0;
    unit_processing = 1'b0; reset = 1'b1;
    #1;
    chk("rstmid_no_illegal", 32'(err_illegal), 0);
    step();
    reset = 1'b0;
    #1;
    chk("rstmid_ready", 32'(in_ready), 1);

    // Reset during WAIT; a late unit_valid must not produce a writeback
    send(t); step(); in_valid = 1'b0;
    unit_processing = 1'b1; unit_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; unit_valid = 1'b1; unit_rd_val = 32'h0000_00AA;
    #1;
    chk("rstwait_ready", 32'(in_ready), 1);
    chk("rstwait_hold_clr", unit_rs1_val, 0);
    chk("rstwait_no_wb", 32'(wb_valid), 0);
    chk("rstwait_no_to", 32'(err_timeout), 0);
    step();
    unit_processing = 1'b0; unit_valid = 1'b0;
    #1;
    chk("rstwait_still_idle", 32'(wb_valid), 0);

    // Random shifts, unit latencies and writeback stalls
    for (int n = 0; n < 40; n++) begin
      t.opc = ($urandom_range(0, 1) == 0) ? OP : OP_IMM;
      t.f3  = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b101;
      case ($urandom_range(0, 5))
        0:       t.f7 = 7'h20;
        1:       t.f7 = 7'($urandom_range(1, 127));
        default: t.f7 = 7'h00;
      endcase
      t.imm = $urandom;
      t.rs1 = $urandom;
      t.rs2 = $urandom;
      t.rd  = 5'($urandom);
      waits = ($urandom_range(0, 7) == 0) ? TO + 2 : int'($urandom_range(0, 4));
      stall = int'($urandom_range(0, 2));
      do_txn(t, waits, stall, ref_result(t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
